// File: rtl/gauss_pkg.sv
// rtl/gauss_pkg.sv - shared state type, strip geometry and SRAM column packing for the Gaussian sequencer
package gauss_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STRIP,
    NEXT,
    FLUSH,
    DONE
  } frame_state_t;

  localparam int STRIP_ROWS = 9;
  localparam int STRIP_STEP = 7;
  localparam int PRIME_COLS = 8;
  localparam int SRAM_W     = 8 * STRIP_ROWS;

  // Bank k of a column word lives in bits [8k+7:8k].
  function automatic logic [7:0] bank_byte(input logic [SRAM_W-1:0] col, input int k);
    return col[8*k +: 8];
  endfunction

  function automatic logic [SRAM_W-1:0] set_bank(input logic [SRAM_W-1:0] col, input int k,
                                                 input logic [7:0] b);
    logic [SRAM_W-1:0] r;
    r = col;
    r[8*k +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/gauss_frame_ctrl_if.sv
// rtl/gauss_frame_ctrl_if.sv - control, SRAM read and window output signals of the frame sequencer
interface gauss_frame_ctrl_if #(
  parameter int COL_W = 6,
  parameter int ROW_W = 7
);
  import gauss_pkg::*;

  logic              start;
  logic [1:0]        cfg_shift;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;
  logic [SRAM_W-1:0] sram_col;
  logic [SRAM_W-1:0] col_data;
  logic              nineXnine_enable;
  logic [1:0]        gauss_shift;
  logic              out_valid;
  logic              out_ready;
  logic [ROW_W-1:0]  out_row;
  logic [COL_W-1:0]  out_col;

  modport master (
    input  start, cfg_shift, sram_col, out_ready,
    output busy, done, rd_en, rd_row, rd_col, col_data, nineXnine_enable,
           gauss_shift, out_valid, out_row, out_col
  );

  modport slave (
    output start, cfg_shift, sram_col, out_ready,
    input  busy, done, rd_en, rd_row, rd_col, col_data, nineXnine_enable,
           gauss_shift, out_valid, out_row, out_col
  );

endinterface

// File: rtl/gauss_col_skid.sv
// rtl/gauss_col_skid.sv - one-entry column holding register for SRAM data that cannot shift yet
module gauss_col_skid
  import gauss_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              unload,
  input  logic [SRAM_W-1:0] din,
  output logic              full,
  output logic [SRAM_W-1:0] dout
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/gauss_frame_ctrl.sv
// rtl/gauss_frame_ctrl.sv - walks the image in overlapping 9-row strips, feeding columns and tracking windows
module gauss_frame_ctrl
  import gauss_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 65,
  parameter int COL_W  = $clog2(WIDTH),
  parameter int ROW_W  = $clog2(HEIGHT)
) (
  input logic clk,
  input logic rst,
  gauss_frame_ctrl_if.master bus
);

  if (WIDTH < STRIP_ROWS || HEIGHT < STRIP_ROWS ||
      (HEIGHT - STRIP_ROWS) % STRIP_STEP != 0) begin : g_bad_geometry
    $error("gauss_frame_ctrl: illegal WIDTH/HEIGHT");
  end

  localparam logic [COL_W:0]   LAST_COL = (COL_W+1)'(WIDTH);
  localparam logic [COL_W:0]   PRIME    = (COL_W+1)'(PRIME_COLS);
  localparam logic [ROW_W-1:0] STEP     = ROW_W'(STRIP_STEP);

  frame_state_t      state;
  logic [COL_W:0]    rd_cnt;
  logic [COL_W:0]    shift_cnt;
  logic [COL_W-1:0]  win_col;
  logic [ROW_W-1:0]  row_base;
  logic              pend;
  logic              skid_full;
  logic [SRAM_W-1:0] skid_data;
  logic              rd_go, shift_go, accept, strip_end, last_strip;
  logic              busy_q, done_q, valid_q;
  logic [1:0]        shift_q;
  logic [ROW_W-1:0]  out_row_q;
  logic [COL_W-1:0]  out_col_q;

  assign accept     = valid_q & bus.out_ready;
  assign shift_go   = (state == STRIP) & (pend | skid_full) & (~valid_q | bus.out_ready);
  // A return that cannot shift this cycle will occupy the skid, so no further read may be launched.
  assign rd_go      = (state == STRIP) & (rd_cnt < LAST_COL) & ~skid_full & ~(pend & ~shift_go);
  assign strip_end  = (state == STRIP) & (shift_cnt == LAST_COL) & (~valid_q | bus.out_ready);
  assign last_strip = (int'(row_base) + STRIP_ROWS) >= HEIGHT;
  assign win_col    = COL_W'(shift_cnt - PRIME);

  gauss_col_skid u_skid (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .load   (pend & ~shift_go),
    .unload (skid_full & shift_go),
    .din    (bus.sram_col),
    .full   (skid_full),
    .dout   (skid_data)
  );

  assign bus.rd_en            = rd_go;
  assign bus.rd_row           = row_base;
  assign bus.rd_col           = rd_cnt[COL_W-1:0];
  assign bus.col_data         = skid_full ? skid_data : (pend ? bus.sram_col : '0);
  assign bus.nineXnine_enable = shift_go;
  assign bus.gauss_shift      = shift_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.out_valid        = valid_q;
  assign bus.out_row          = out_row_q;
  assign bus.out_col          = out_col_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shift_q  <= '0;
      row_base <= '0;
      rd_cnt   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          shift_q  <= bus.cfg_shift;
          row_base <= '0;
          rd_cnt   <= '0;
          busy_q   <= 1'b1;
          state    <= STRIP;
        end
        STRIP: begin
          if (rd_go) rd_cnt <= rd_cnt + 1'b1;
          if (strip_end) state <= last_strip ? FLUSH : NEXT;
        end
        NEXT: begin
          row_base <= row_base + STEP;
          rd_cnt   <= '0;
          state    <= STRIP;
        end
        FLUSH: if (!valid_q) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The first PRIME_COLS shifts of a strip only fill the 9x9 buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      shift_cnt <= '0;
      valid_q   <= 1'b0;
      out_row_q <= '0;
      out_col_q <= '0;
    end else begin
      pend <= rd_go;
      if (state == IDLE || state == NEXT) shift_cnt <= '0;
      else if (shift_go) shift_cnt <= shift_cnt + 1'b1;
      if (shift_go && shift_cnt >= PRIME) begin
        valid_q   <= 1'b1;
        out_row_q <= row_base;
        out_col_q <= win_col;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gauss_frame_ctrl.sv
// tb/tb_gauss_frame_ctrl.sv - randomized self-checking bench for gauss_frame_ctrl against a raster-order model
module tb_gauss_frame_ctrl;
  import gauss_pkg::*;

  localparam int W      = 10;
  localparam int H      = 16;
  localparam int CW     = $clog2(W);
  localparam int RW     = $clog2(H);
  localparam int STRIPS = (H - STRIP_ROWS) / STRIP_STEP + 1;
  localparam int WINS   = STRIPS * (W - PRIME_COLS);

  logic clk = 1'b0;
  logic rst = 1'b1;

  gauss_frame_ctrl_if #(.COL_W(CW), .ROW_W(RW)) bus ();

  gauss_frame_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] col_word(input int row, input int col);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < STRIP_ROWS; k++) w = set_bank(w, k, 8'((row + k) * 13 + col * 7 + 1));
    return w;
  endfunction

  logic [71:0] exp_col[$];
  int          exp_win[$];
  logic [1:0]  exp_shift;

  // Raster order: each strip reads every column once; window c-8 completes on column c.
  task automatic build_expect();
    exp_col.delete();
    exp_win.delete();
    for (int rb = 0; rb + STRIP_ROWS <= H; rb += STRIP_STEP)
      for (int c = 0; c < W; c++) begin
        exp_col.push_back(col_word(rb, c));
        if (c >= PRIME_COLS) exp_win.push_back(rb * 256 + c - PRIME_COLS);
      end
  endtask

  int mode = 0;
  int stall_left = 0;
  bit stall_done = 0;

  initial begin
    bus.start     = 1'b0;
    bus.cfg_shift = 2'b00;
    bus.out_ready = 1'b1;
    bus.sram_col  = '0;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (mode)
      1: bus.out_ready = ($urandom_range(0, 1) == 1);
      2: bus.out_ready = ~bus.out_ready;
      3: begin
        if (stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
        end else if (!stall_done && bus.out_valid) begin
          stall_done    = 1;
          stall_left    = 4;
          bus.out_ready = 1'b0;
        end else begin
          bus.out_ready = 1'b1;
        end
      end
      default: bus.out_ready = 1'b1;
    endcase
  end

  initial begin : sram_model
    logic          r;
    logic [RW-1:0] a;
    logic [CW-1:0] b;
    forever begin
      @(negedge clk);
      r = bus.rd_en;
      a = bus.rd_row;
      b = bus.rd_col;
      @(posedge clk);
      #1;
      bus.sram_col = r ? col_word(int'(a), int'(b)) : {8'h00, $urandom(), $urandom()};
    end
  end

  bit          mon_en = 0;
  int          rd_seen, win_seen, done_seen, stall_rd;
  bit          prev_stall;
  logic [7:0]  prev_pos;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (bus.rd_en) rd_seen++;
      if (bus.done) begin
        done_seen++;
        check("busy_at_done", bus.busy, 0);
      end
      if (bus.nineXnine_enable) begin
        if (exp_col.size() == 0) check("extra_col", 1, 0);
        else check("col_data", bus.col_data, exp_col.pop_front());
        check("gauss_shift", bus.gauss_shift, exp_shift);
      end
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_pos", {bus.out_row, bus.out_col}, prev_pos);
      end
      if (bus.out_valid && bus.out_ready) begin
        win_seen++;
        if (exp_win.size() == 0) check("extra_win", 1, 0);
        else check("window", int'(bus.out_row) * 256 + int'(bus.out_col), exp_win.pop_front());
      end
      if (bus.out_valid && !bus.out_ready) begin
        if (bus.rd_en) begin
          stall_rd++;
          check("stall_reads", stall_rd <= 1, 1);
        end
      end else begin
        stall_rd = 0;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_pos   = {bus.out_row, bus.out_col};
    end else begin
      prev_stall = 0;
      stall_rd   = 0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {bus.busy, bus.done, bus.rd_en, bus.nineXnine_enable, bus.out_valid}, 0);
    check({tag, "_pos"}, {bus.rd_row, bus.rd_col, bus.out_row, bus.out_col, bus.gauss_shift}, 0);
    check({tag, "_col_data"}, bus.col_data, 0);
  endtask

  task automatic pulse_reset();
    mon_en = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic launch(input logic [1:0] shf, input int m);
    mode       = m;
    stall_done = 0;
    stall_left = 0;
    build_expect();
    exp_shift = shf;
    rd_seen   = 0;
    win_seen  = 0;
    done_seen = 0;
    @(posedge clk);
    #1;
    bus.cfg_shift = shf;
    bus.start     = 1'b1;
    mon_en        = 1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic run_frame(input logic [1:0] shf, input int m, input bit restart_mid,
                           input bit change_cfg);
    int n;
    launch(shf, m);
    n = 0;
    while (!bus.done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (change_cfg && n == 6) bus.cfg_shift = ~shf;
      if (restart_mid && n == 8) bus.start = 1'b1;
      if (n == 9) bus.start = 1'b0;
    end
    check("done_timeout", n < 2000, 1);
    if (m == 0) check("frame_len", n <= STRIPS * (W + 2) + 6, 1);
    repeat (3) @(posedge clk);
    #1 mon_en = 0;
    check("windows", win_seen, WINS);
    check("win_left", exp_win.size(), 0);
    check("col_left", exp_col.size(), 0);
    check("rd_count", rd_seen, STRIPS * W);
    check("done_count", done_seen, 1);
    check("busy_after", bus.busy, 0);
    check("gauss_shift_hold", bus.gauss_shift, shf);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    run_frame(2'b10, 0, 0, 1);
    pulse_reset();
    check_reset_outputs("post_frame_rst");

    run_frame(2'b01, 3, 0, 0);
    run_frame(2'b11, 2, 1, 0);

    launch(2'b01, 0);
    n = 0;
    while (!(bus.out_valid && bus.out_row == RW'(STRIP_STEP)) && n < 500) begin
      @(posedge clk);
      #1 n++;
    end
    check("reach_strip2", n < 500, 1);
    pulse_reset();
    check_reset_outputs("mid_frame_rst");
    run_frame(2'b00, 0, 0, 0);

    repeat (6) run_frame(2'($urandom_range(0, 3)), 1, $urandom_range(0, 1) == 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gauss_frame_ctrl.md
# gauss_frame_ctrl

Frame sequencer for the Gaussian datapath. Walks a WIDTH×HEIGHT image in 9-row strips and issues column reads to the 9-bank SRAM. It drives `nineXnine_enable` and `gauss_shift` into the Gaussian block, and handles output flow with a valid/ready handshake. A one-column skid register absorbs SRAM read latency when the output stalls.

## Interface
- WIDTH, 64, image columns; must be ≥ 9.
- HEIGHT, 65, image rows; (HEIGHT−9) must be a multiple of 7. Illegal values are rejected by an elaboration assertion.
- COL_W, $clog2(WIDTH), column index width.
- ROW_W, $clog2(HEIGHT), row index width.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame start pulse; sampled only in IDLE.
- cfg_shift  in  2  kernel select; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until `done`.
- done  out  1  one-cycle pulse at frame end.
- rd_en  out  1  SRAM column read strobe.
- rd_row  out  ROW_W  strip base row; banks A..I return rows rd_row..rd_row+8.
- rd_col  out  COL_W  column being read.
- sram_col  in  72  bank data A..I, bits [8k+7:8k] = bank k; valid exactly 1 cycle after rd_en.
- col_data  out  72  column presented to the Gaussian block; driven from SRAM or the skid register.
- nineXnine_enable  out  1  shift the presented column into the 9×9 buffer.
- gauss_shift  out  2  latched cfg_shift; constant for the whole frame.
- out_valid  out  1  the current `gauss_out` window is valid.
- out_ready  in  1  consumer accepts the window.
- out_row  out  ROW_W  strip base row of the valid window.
- out_col  out  COL_W  left column of the valid window.

## Operation
- States (enum in package): IDLE, STRIP, NEXT, FLUSH, DONE.
- **IDLE**
  - start=1 → latch cfg_shift; row_base=0; rd_col=0; go to STRIP.
- **STRIP: reads**
  - Issue rd_en while rd_col < WIDTH, the skid is empty, and no read is in flight that would overflow the skid.
  - rd_col increments on each rd_en.
- **STRIP: shift**
  - Condition: column data is available (SRAM return or skid full) AND (out_valid==0 OR out_ready==1).
  - When the condition holds, nineXnine_enable=1; skid data takes priority over SRAM data.
  - Returning SRAM data that cannot shift is captured into the skid. At most one entry is held.
- **Shift counter** (per strip, 0..WIDTH)
  - Shifts 1..8 prime the buffer and produce no output.
  - Shift n≥9 sets out_valid on the next cycle, with out_col=n−9 and out_row=row_base.
- **out_valid clearing**
  - Clears on out_valid&&out_ready, unless a new shift happens in the same cycle.
- **End of strip**
  - After shift WIDTH, wait for the final window to be accepted.
  - If row_base+9 < HEIGHT → NEXT; otherwise → FLUSH.
- **NEXT** (1 cycle): row_base += 7; rd_col=0; → STRIP.
- **FLUSH**: → DONE when out_valid==0.
- **DONE** (1 cycle): done=1, busy=0; → IDLE.
- start outside IDLE is ignored.
- rst in any state: next cycle is IDLE.
  - All outputs 0, skid empty, counters 0, gauss_shift=0.
  - In-flight SRAM data is discarded.

## Timing
- Reset values: every output is 0.
- Read latency: rd_en in cycle t; nineXnine_enable in cycle t+1 when not stalled; out_valid in cycle t+2 for shift ≥ 9.
- Throughput with no stalls: one window per cycle. Frame length = strips·(WIDTH+2)+O(1) cycles.
- Stall: with out_ready=0, at most one further column is read. The skid absorbs it, and rd_en holds low until the skid drains.
- Simultaneous accept and shift: out_valid stays 1 and out_col advances by 1.
- `out_row`, `out_col`, and `gauss_out` are stable while out_valid && !out_ready.

## Structure
- gauss_pkg:
  - state enum;
  - STRIP_ROWS=9, STRIP_STEP=7, PRIME_COLS=8;
  - sram column packing helpers.
- Sub-module gauss_col_skid: 1-entry, 72-bit skid with full flag, load/unload, and a sync-reset clear.
- Top-level holds the FSM, the counters, and the handshake logic.

## Test plan
- WIDTH=10, HEIGHT=16, out_ready=1, start pulse → 4 windows:
  - (row,col) = (0,0), (0,1), (7,0), (7,1);
  - rd_en count = 20;
  - done exactly once;
  - busy low afterwards.
- cfg_shift=2'b10 at start, then changed mid-frame → gauss_shift stays 2'b10 until DONE, then reads 0 after rst.
- out_ready=0 for 5 cycles after the first out_valid → out_col held at 0, skid fills once, rd_en low, no window lost or duplicated.
- out_ready toggling 1010… → every window delivered exactly once, in raster order, with correct out_row/out_col.
- rst asserted during strip 2 → all outputs 0 next cycle; a fresh start yields the full 4-window sequence from (0,0).
- start while busy → ignored; the frame completes normally with a single done.
